ram_write_arbiter: RTL



---
 rtl/ram_write_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ram_write_arbiter.sv
// Write-port sequencer for a 512x8 dual-port RAM: round-robin between two requesters,
// plus a clear engine that fills every address with a captured value.
module ram_write_arbiter #(
    parameter int unsigned addr_width = 9,
    parameter int unsigned data_width = 8
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  A_REQ,
    input  logic [addr_width-1:0] A_ADDR,
    input  logic [data_width-1:0] A_DATA,
    output logic                  A_GNT,
    input  logic                  B_REQ,
    input  logic [addr_width-1:0] B_ADDR,
    input  logic [data_width-1:0] B_DATA,
    output logic                  B_GNT,
    input  logic                  CLEAR,
    input  logic [data_width-1:0] FILL,
    output logic                  CLEAR_BUSY,
    output logic                  WRITE_EN,
    output logic [addr_width-1:0] WADDR,
    output logic [data_width-1:0] DIN
);

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    state_e                state_q, state_d;
    logic [addr_width-1:0] cnt_q, cnt_d;
    logic [data_width-1:0] fill_q, fill_d;
    logic                  last_b_q, last_b_d;
    logic                  a_gnt_q, a_gnt_d;
    logic                  b_gnt_q, b_gnt_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic [addr_width-1:0] waddr_q, waddr_d;
    logic [data_width-1:0] din_q, din_d;

    logic elig_a, elig_b, grant_a, grant_b;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        last_b_d = last_b_q;
        a_gnt_d  = 1'b0;
        b_gnt_d  = 1'b0;
        we_d     = 1'b0;
        busy_d   = 1'b0;
        waddr_d  = waddr_q;
        din_d    = din_q;
        // A requester whose grant is showing this cycle is masked, so a held REQ
        // cannot be written twice.
        elig_a   = A_REQ & ~a_gnt_q;
        elig_b   = B_REQ & ~b_gnt_q;
        grant_a  = 1'b0;
        grant_b  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (CLEAR) begin
                    state_d = StSweep;
                    fill_d  = FILL;
                    cnt_d   = '0;
                end else begin
                    grant_a = elig_a & (~elig_b | last_b_q);
                    grant_b = elig_b & ~grant_a;
                    if (grant_a) begin
                        a_gnt_d  = 1'b1;
                        we_d     = 1'b1;
                        waddr_d  = A_ADDR;
                        din_d    = A_DATA;
                        last_b_d = 1'b0;
                    end else if (grant_b) begin
                        b_gnt_d  = 1'b1;
                        we_d     = 1'b1;
                        waddr_d  = B_ADDR;
                        din_d    = B_DATA;
                        last_b_d = 1'b1;
                    end
                end
            end
            StSweep: begin
                we_d    = 1'b1;
                busy_d  = 1'b1;
                waddr_d = cnt_q;
                din_d   = fill_q;
                cnt_d   = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            fill_q   <= '0;
            last_b_q <= 1'b1;
            a_gnt_q  <= 1'b0;
            b_gnt_q  <= 1'b0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            waddr_q  <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            last_b_q <= last_b_d;
            a_gnt_q  <= a_gnt_d;
            b_gnt_q  <= b_gnt_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            waddr_q  <= waddr_d;
            din_q    <= din_d;
        end
    end

    assign A_GNT      = a_gnt_q;
    assign B_GNT      = b_gnt_q;
    assign WRITE_EN   = we_q;
    assign CLEAR_BUSY = busy_q;
    assign WADDR      = waddr_q;
    assign DIN        = din_q;

endmodule
